pix_stream_gen: RTL and testbench
=================================

// Module: pix_stream_gen
// PURPOSE
//  Source end of the raster pixel stream (pix,row,col) consumed by the image filters (Sobel/edge-thin).
//  Scans a fixed-timing 640x480@60 raster (800x525 total) at pixel clock.
//  Reads each active pixel from a synchronous frame RAM and emits it, with its coordinates and VGA syncs.
//  Stream is produced one pixel per clk, with no stalls.
// PARAMETERS
//  H_ACTIVE 640  active pixels per line
//  H_FP     16   horizontal front porch (clks)
//  H_SYNC   96   hsync pulse width (clks)
//  H_BP     48   horizontal back porch; H_TOTAL = sum = 800
//  V_ACTIVE 480  active lines per frame
//  V_FP     10   vertical front porch (lines)
//  V_SYNC   2    vsync pulse width (lines)
//  V_BP     33   vertical back porch; V_TOTAL = sum = 525
//  ADDR_W   19   frame RAM address width (>= clog2(H_ACTIVE*V_ACTIVE))
//  RD_LAT   1    frame RAM read latency in clks (1 or 2)
// PORTS
//  clk        in   1       pixel clock (25 MHz)
//  rst        in   1       synchronous reset, active-high
//  en         in   1       1 = run frames back-to-back; 0 = stop after the current frame completes
//  mem_addr   out  ADDR_W  frame RAM read address, row-major (row*H_ACTIVE + col)
//  mem_rdata  in   8       frame RAM data, valid RD_LAT clks after mem_addr
//  pix        out  8       pixel value; 0 outside the active region
//  row        out  13      line counter 0..V_TOTAL-1 (runs through blanking)
//  col        out  13      pixel counter 0..H_TOTAL-1 (runs through blanking)
//  active     out  1       1 when row<V_ACTIVE && col<H_ACTIVE
//  hsync      out  1       active-low horizontal sync
//  vsync      out  1       active-low vertical sync
//  frame_done out  1       one-clk pulse on the last pixel (row=V_TOTAL-1, col=H_TOTAL-1)
// BEHAVIOUR
//  Reset values:
//   - state=IDLE
//   - pix/row/col/mem_addr/active/frame_done = 0
//   - hsync = vsync = 1
//   - internal counters hc = vc = 0
//   - any frame in progress is abandoned and no frame_done is issued
//  State machine:
//   - IDLE: counters are held at 0; outputs keep reset values.
//   - IDLE -> RUN: on the first clk with en=1.
//   - RUN: hc increments every clk. At hc=H_TOTAL-1, hc wraps to 0 and vc increments.
//     At vc=V_TOTAL-1 with hc=H_TOTAL-1, vc wraps to 0.
//   - End of frame: if en=1, stay in RUN with no gap clock; if en=0, go to IDLE.
//     en is sampled only at this point, so dropping en mid-frame never truncates a frame.
//  Addressing:
//   - mem_addr is a running counter, not a multiply.
//   - Cleared when hc=0 and vc=0; incremented after each active (hc,vc).
//   - Held during blanking. Maximum value H_ACTIVE*V_ACTIVE-1 = 307199.
//  Alignment:
//   - row, col, active, hsync, vsync and frame_done are the (hc,vc)-derived values delayed RD_LAT clks.
//   - This aligns them with mem_rdata.
//   - Pipeline latency from counter to outputs = RD_LAT clks.
//   - Pipeline stages are cleared by reset; on IDLE entry they drain with pix=0 and active=0.
//  Output data:
//   - pix = active ? mem_rdata : 8'd0.
//  Sync timing:
//   - hsync is low for H_ACTIVE+H_FP <= col < H_ACTIVE+H_FP+H_SYNC (656..751).
//   - vsync is low for V_ACTIVE+V_FP <= row < V_ACTIVE+V_FP+V_SYNC (490..491).
//   - Both are evaluated on the aligned row/col.
//  Width rules:
//   - row and col are 13-bit and zero-extended from the counters.
//   - Downstream line buffers use col[9:0]; col never exceeds 799, so no alias inside a line.
// TESTING
//  1. Assert rst 3 clks with en=1 -> pix=0, row=col=0, hsync=vsync=1, active=0; first RUN clk mem_addr=0,
//     RD_LAT clks later active=1 and pix equals RAM[0].
//  2. Load RAM[i]=i[7:0], then run one line -> col=0..639 with pix=col[7:0]; col 640..799 with pix=0;
//     hsync low exactly at col 656..751; the next clk shows row=1, col=0, pix=RAM[640].
//  3. Run a full frame -> frame_done pulses once, at row=524 and col=799; mem_addr peaks at 307199;
//     vsync low only for rows 490..491; the next clk shows row=0, col=0.
//  4. Drop en at row 100 -> the frame completes to row 524 / col 799 with frame_done, then IDLE:
//     row=col=0, active=0, hsync=vsync=1 held.
//  5. Assert rst at row 200, col 300 -> next clk all outputs at reset values with no frame_done;
//     after release with en=1, scanning restarts at row 0, col 0, mem_addr 0.
//  6. Set RD_LAT=2 -> same as scenario 2, with pix still equal to RAM[row*640+col] on each aligned clk.

Source files
------------

// File: rtl/pix_stream_gen.sv
// Raster pixel-stream source: scans a fixed-timing frame, fetches active pixels from a
// synchronous frame RAM and emits them aligned with coordinates, syncs and frame_done.
module pix_stream_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int ADDR_W   = 19,
  parameter int RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        pix,
  output logic [12:0]       row,
  output logic [12:0]       col,
  output logic              active,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_done
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int unsigned LAT = RD_LAT;

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_ALAST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_ALAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [12:0] row;
    logic [12:0] col;
    logic        act;
    logic        hs;
    logic        vs;
    logic        fd;
  } tap_t;

  localparam tap_t TAP_IDLE = '{row: '0, col: '0, act: 1'b0, hs: 1'b1, vs: 1'b1, fd: 1'b0};

  state_t            state_q, state_d;
  logic [HW-1:0]     hc;
  logic [VW-1:0]     vc;
  logic [ADDR_W-1:0] addr;
  logic              run, last, act_last;
  tap_t              cur;
  tap_t              pipe [LAT];

  assign run      = (state_q == RUN);
  assign last     = (hc == H_LAST) && (vc == V_LAST);
  assign act_last = (hc == H_ALAST) && (vc == V_ALAST);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // en is only consulted at the end of a frame, so a frame is never cut short
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (last && !en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      hc   <= '0;
      vc   <= '0;
      addr <= '0;
    end else begin
      if (hc == H_LAST) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
      end else begin
        hc <= hc + 1'b1;
      end
      // Running address saturates on the last active pixel and restarts with the frame
      if (last)
        addr <= '0;
      else if (cur.act && !act_last)
        addr <= addr + 1'b1;
    end
  end

  always_comb begin
    cur     = TAP_IDLE;
    cur.row = 13'(vc);
    cur.col = 13'(hc);
    cur.act = run && (hc < H_ACT) && (vc < V_ACT);
    cur.hs  = ~(run && (hc >= HS_BEG) && (hc < HS_END));
    cur.vs  = ~(run && (vc >= VS_BEG) && (vc < VS_END));
    cur.fd  = run && last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < LAT; i++) pipe[i] <= TAP_IDLE;
    end else begin
      pipe[0] <= cur;
      for (int unsigned i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign mem_addr   = addr;
  assign row        = pipe[LAT-1].row;
  assign col        = pipe[LAT-1].col;
  assign active     = pipe[LAT-1].act;
  assign hsync      = pipe[LAT-1].hs;
  assign vsync      = pipe[LAT-1].vs;
  assign frame_done = pipe[LAT-1].fd;
  assign pix        = active ? mem_rdata : '0;

endmodule

// File: tb/tb_pix_stream_gen.sv
// Directed bench: full-size raster (RD_LAT=1) for reset and line checks, plus a reduced
// raster (RD_LAT=2) for full-frame, en-drop and mid-frame reset checks.
module tb_pix_stream_gen;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Full-size instance
  logic        rst_a, en_a;
  logic [18:0] addr_a;
  logic [7:0]  rdata_a, pix_a;
  logic [12:0] row_a, col_a;
  logic        act_a, hs_a, vs_a, fd_a;

  // Reduced raster: 16+2+3+3=24 clks/line, 6+2+2+2=12 lines
  logic        rst_b, en_b;
  logic [7:0]  addr_b;
  logic [7:0]  rb1, rdata_b, pix_b;
  logic [12:0] row_b, col_b;
  logic        act_b, hs_b, vs_b, fd_b;

  pix_stream_gen u_dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .mem_addr(addr_a), .mem_rdata(rdata_a),
    .pix(pix_a), .row(row_a), .col(col_a), .active(act_a), .hsync(hs_a),
    .vsync(vs_a), .frame_done(fd_a)
  );

  pix_stream_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .ADDR_W(8), .RD_LAT(2)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .mem_addr(addr_b), .mem_rdata(rdata_b),
    .pix(pix_b), .row(row_b), .col(col_b), .active(act_b), .hsync(hs_b),
    .vsync(vs_b), .frame_done(fd_b)
  );

  // Frame RAMs holding RAM[i] = i[7:0], with one and two clocks of read latency
  always_ff @(posedge clk) begin
    rdata_a <= addr_a[7:0];
    rb1     <= addr_b[7:0];
    rdata_b <= rb1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_px(input string tag, input int ha, hfp, hsw, ht, va, vfp, vsw, vt,
                        input int r, c, input logic [12:0] orow, ocol, input logic [7:0] opix,
                        input logic oact, ohs, ovs, ofd);
    bit a;
    a = (r < va) && (c < ha);
    check({tag, ".row"}, orow, r);
    check({tag, ".col"}, ocol, c);
    check({tag, ".active"}, oact, a);
    check({tag, ".pix"}, opix, a ? ((r * ha + c) & 255) : 0);
    check({tag, ".hsync"}, ohs, !(c >= ha + hfp && c < ha + hfp + hsw));
    check({tag, ".vsync"}, ovs, !(r >= va + vfp && r < va + vfp + vsw));
    check({tag, ".frame_done"}, ofd, (r == vt - 1) && (c == ht - 1));
  endtask

  task automatic px_a(input string tag, input int r, c);
    chk_px(tag, 640, 16, 96, 800, 480, 10, 2, 525, r, c,
           row_a, col_a, pix_a, act_a, hs_a, vs_a, fd_a);
  endtask

  task automatic px_b(input string tag, input int r, c);
    chk_px(tag, 16, 2, 3, 24, 6, 2, 2, 12, r, c,
           row_b, col_b, pix_b, act_b, hs_b, vs_b, fd_b);
  endtask

  task automatic idle_b(input string tag);
    check({tag, ".row"}, row_b, 0);
    check({tag, ".col"}, col_b, 0);
    check({tag, ".pix"}, pix_b, 0);
    check({tag, ".active"}, act_b, 0);
    check({tag, ".hsync"}, hs_b, 1);
    check({tag, ".vsync"}, vs_b, 1);
    check({tag, ".frame_done"}, fd_b, 0);
    check({tag, ".mem_addr"}, addr_b, 0);
  endtask

  task automatic adv(inout int r, inout int c, input int ht, input int vt);
    c++;
    if (c == ht) begin
      c = 0;
      r++;
      if (r == vt) r = 0;
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r, c, fdn, peak;
    rst_a = 1'b1; en_a = 1'b1;
    rst_b = 1'b1; en_b = 1'b0;

    // Reset state with en held high
    repeat (3) tick();
    check("rst.pix", pix_a, 0);
    check("rst.row", row_a, 0);
    check("rst.col", col_a, 0);
    check("rst.hsync", hs_a, 1);
    check("rst.vsync", vs_a, 1);
    check("rst.active", act_a, 0);
    check("rst.frame_done", fd_a, 0);
    check("rst.mem_addr", addr_a, 0);
    rst_a = 1'b0;

    tick();
    check("first_run.mem_addr", addr_a, 0);
    check("first_run.active", act_a, 0);
    tick();
    px_a("first_pix", 0, 0);

    // One full line, then the first pixel of row 1 (RAM[640] = 128)
    r = 0; c = 0;
    repeat (800) begin
      tick();
      adv(r, c, 800, 525);
      px_a("line", r, c);
    end
    check("line.row1_pix", pix_a, 128);
    en_a = 1'b0;

    // Reduced raster, RD_LAT=2
    idle_b("b_rst");
    en_b = 1'b1;
    rst_b = 1'b0;
    tick();
    check("b_first_run.mem_addr", addr_b, 0);
    check("b_first_run.active", act_b, 0);
    tick();
    check("b_lat.active", act_b, 0);
    tick();
    px_b("b_first_pix", 0, 0);

    // Full frame: one frame_done, address peak, wrap to (0,0)
    r = 0; c = 0; fdn = int'(fd_b); peak = int'(addr_b);
    repeat (287) begin
      tick();
      adv(r, c, 24, 12);
      px_b("frame", r, c);
      if (fd_b) fdn++;
      if (int'(addr_b) > peak) peak = int'(addr_b);
    end
    check("frame.done_count", fdn, 1);
    check("frame.addr_peak", peak, 95);
    tick();
    adv(r, c, 24, 12);
    px_b("frame.wrap", r, c);

    // Drop en at row 2: frame still completes, then outputs idle
    repeat (48) begin
      tick();
      adv(r, c, 24, 12);
      px_b("pre_drop", r, c);
    end
    en_b = 1'b0;
    fdn = 0;
    repeat (239) begin
      tick();
      adv(r, c, 24, 12);
      px_b("drain", r, c);
      if (fd_b) fdn++;
    end
    check("drain.done_count", fdn, 1);
    check("drain.last_row", row_b, 11);
    check("drain.last_col", col_b, 23);
    repeat (20) begin
      tick();
      idle_b("idle");
    end

    // Restart, reset at row 4 col 7, restart again from the origin
    en_b = 1'b1;
    tick();
    idle_b("restart");
    tick();
    check("restart.lat_active", act_b, 0);
    tick();
    r = 0; c = 0;
    px_b("restart.first", r, c);
    repeat (103) begin
      tick();
      adv(r, c, 24, 12);
      px_b("pre_rst", r, c);
    end
    check("pre_rst.row", row_b, 4);
    check("pre_rst.col", col_b, 7);
    rst_b = 1'b1;
    tick();
    idle_b("mid_rst");
    rst_b = 1'b0;
    tick();
    check("post_rst.mem_addr", addr_b, 0);
    check("post_rst.active", act_b, 0);
    tick();
    check("post_rst.lat_active", act_b, 0);
    tick();
    r = 0; c = 0;
    px_b("post_rst.first", r, c);
    repeat (30) begin
      tick();
      adv(r, c, 24, 12);
      px_b("post_rst", r, c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
